clock_divider_prog: RTL and testbench
=====================================

// Module: clock_divider_prog
// PURPOSE
//  Multi-channel runtime-programmable clock divider for the NCO datapath. Each channel
//  divides clk_in by an integer D (output period = D clk_in cycles). Outputs are registered
//  clk_out levels plus a one-cycle tick strobe, so downstream logic can use either a derived
//  clock or a clock enable. Divisors are reprogrammed through a valid/ready config port.
//  Updates take effect only on a period boundary, so a divisor change never glitches clk_out.
// PARAMETERS
//  CHANNELS     4   number of independent divider channels (>=1)
//  DIV_WIDTH    16  width of divisor and per-channel counter
//  DEFAULT_DIV  2   divisor loaded into every channel at reset (2..2^DIV_WIDTH-1)
//  CHAN_W       clog2(CHANNELS), min 1  (derived) width of cfg_chan
// PORTS
//  clk_in     in   1          single system clock
//  rst_n      in   1          asynchronous active-low reset
//  cfg_valid  in   1          config write request
//  cfg_ready  out  1          config write accepted when cfg_valid & cfg_ready
//  cfg_chan   in   CHAN_W     target channel of config write
//  cfg_div    in   DIV_WIDTH  new divisor D for target channel
//  cfg_err    out  1          1-cycle pulse: write rejected (D<2 or cfg_chan>=CHANNELS)
//  en         in   CHANNELS   per-channel run enable
//  clk_out    out  CHANNELS   divided clock per channel, registered
//  tick       out  CHANNELS   1-cycle pulse on the clk_in cycle where clk_out rises
// BEHAVIOUR
//  Reset (async assert, sync release on clk_in):
//   div_act[c]=DEFAULT_DIV, pend[c]=0, cnt[c]=DEFAULT_DIV-1, clk_out=0, tick=0, cfg_err=0.
//  Per-channel state: div_act (in use), div_pend + pend flag (accepted, not yet applied), cnt.
//  Let H = ceil(div_act/2). High phase = H cycles; low phase = div_act-H cycles.
//   Odd D therefore has high phase one cycle longer than low phase.
//  en[c]=1, on each clk_in edge:
//   cnt==div_act-1 (wrap): cnt<=0; clk_out<=1; tick<=1.
//     If pend: div_act<=div_pend and pend<=0; H for the new period uses the new D.
//   cnt==H-1 (not wrap): clk_out<=0; cnt<=cnt+1; tick<=0.
//   Otherwise: cnt<=cnt+1; tick<=0.
//  en[c]=0: cnt<=div_act-1, clk_out<=0, tick<=0.
//   If pend: div_act<=div_pend and pend<=0 immediately.
//   First edge sampling en=1 wraps: clk_out/tick rise 1 cycle after en is seen high.
//   Deasserting en mid-period forces clk_out low next edge (truncated pulse permitted).
//  Config port:
//   cfg_ready = ~pend[cfg_chan] (combinational). It is 1 for out-of-range cfg_chan, so errors
//    never stall the port.
//   Accept with valid D (>=2) and in-range chan: div_pend<=cfg_div, pend<=1 next edge.
//   Accept with D<2 or chan>=CHANNELS: no state change; cfg_err=1 for the next cycle only.
//   A second write to a channel with pend=1 is back-pressured (ready=0) until the boundary.
//   Write accepted on the same edge as that channel's wrap: not applied at this wrap.
//    It waits for the next wrap (pend set after the apply decision).
//   Channels are independent; writes to other channels are never blocked.
//  Counter never exceeds div_act-1. Apply happens only at wrap, so cnt <= new D-1 always.
//  Latency: tick coincident with the clk_out 0->1 registered transition; no comb out paths.
//  Reset mid-operation: all outputs low asynchronously and pending writes discarded.
// TESTING
//  1 Reset, en=0 -> clk_out=0, tick=0, cfg_ready=1, cfg_err=0. En ch0 (D=2) -> 1010..,
//    rising 1 cycle after en.
//  2 Write ch1 D=4, en ch1 -> clk_out 1100 repeating; tick once per 4 cycles, at each rise.
//  3 Write ch2 D=5, en -> high 3, low 2. Write D=3 at cnt=1 -> D=5 period completes,
//    then 110 repeating, no runt pulse.
//  4 Two writes to ch3 while enabled with D=8 -> 2nd held (ready=0) until wrap, then
//    accepted; 2nd value applied at the following wrap.
//  5 cfg_div=1, and cfg_chan=CHANNELS (when CHANNELS<2^CHAN_W) -> cfg_err one cycle each;
//    divisors unchanged, ready stays 1.
//  6 rst_n low mid-high-phase on all channels -> outputs 0 without clock edge.
//    Release -> restart at DEFAULT_DIV, pend cleared.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider: each channel emits a registered
// divided clock plus a rise-aligned tick, with glitch-free divisor updates at wrap.
module clock_divider_prog #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_err,
  input  logic [CHANNELS-1:0]  en,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  div_t                div_act  [CHANNELS];
  div_t                div_pend [CHANNELS];
  div_t                cnt      [CHANNELS];
  logic [CHANNELS-1:0] pend;

  logic [CHANNELS-1:0] chan_hit;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] at_fall;
  logic [CHANNELS-1:0] wr_hit;
  logic                in_range;
  logic                div_ok;
  logic                accept;
  logic                err_next;

  // Count value on which the high phase ends: ceil(d/2) - 1 == floor((d-1)/2).
  function automatic div_t high_last(input div_t d);
    return (d - div_t'(1)) >> 1;
  endfunction

  always_comb begin
    chan_hit = '0;
    wrap     = '0;
    at_fall  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_hit[c] = (cfg_chan == CHAN_W'(c));
      wrap[c]     = (cnt[c] == div_act[c] - div_t'(1));
      at_fall[c]  = (cnt[c] == high_last(div_act[c]));
    end
  end

  // Out-of-range channels match no bit, so they always see ready and never stall.
  assign in_range  = |chan_hit;
  assign cfg_ready = ~|(chan_hit & pend);
  assign div_ok    = (cfg_div >= div_t'(2));
  assign accept    = cfg_valid & cfg_ready;
  assign wr_hit    = chan_hit & {CHANNELS{accept & div_ok}};
  assign err_next  = accept & ~(in_range & div_ok);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      clk_out <= '0;
      tick    <= '0;
      pend    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        div_act[c]  <= div_t'(DEFAULT_DIV);
        div_pend[c] <= div_t'(DEFAULT_DIV);
        cnt[c]      <= div_t'(DEFAULT_DIV - 1);
      end
    end else begin
      cfg_err <= err_next;
      for (int c = 0; c < CHANNELS; c++) begin
        if (en[c]) begin
          if (wrap[c]) begin
            cnt[c]     <= '0;
            clk_out[c] <= 1'b1;
            tick[c]    <= 1'b1;
            if (pend[c]) begin
              div_act[c] <= div_pend[c];
              pend[c]    <= 1'b0;
            end
          end else begin
            cnt[c]  <= cnt[c] + div_t'(1);
            tick[c] <= 1'b0;
            if (at_fall[c]) clk_out[c] <= 1'b0;
          end
        end else begin
          // Parked one short of wrap so the first enabled edge starts a fresh period.
          clk_out[c] <= 1'b0;
          tick[c]    <= 1'b0;
          if (pend[c]) begin
            div_act[c] <= div_pend[c];
            cnt[c]     <= div_pend[c] - div_t'(1);
            pend[c]    <= 1'b0;
          end else begin
            cnt[c] <= div_act[c] - div_t'(1);
          end
        end
        // Placed after the apply decision: a write landing on a wrap waits for the next one.
        if (wr_hit[c]) begin
          div_pend[c] <= cfg_div;
          pend[c]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: expected clk_out/tick/ready per cycle are
// queued as stimulus is applied and compared as the DUT advances.
module tb_clock_divider_prog;
  localparam int CH = 5;
  localparam int CW = 3;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_err;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CH-1:0] m;
    logic [CH-1:0] clk;
    logic [CH-1:0] tk;
    bit            rdy_care;
    logic          rdy;
  } exp_t;

  exp_t  sb[$];
  string tag;

  clock_divider_prog #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(2)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .en       (en),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Queue one channel's expected waveform; tick is derived as a 0->1 rise of the pattern.
  task automatic push_pat(input int ch, input string pat, input int reps, input logic prev,
                          input bit rc, input logic rv);
    exp_t e;
    logic b;
    logic p;
    p = prev;
    for (int k = 0; k < reps; k++) begin
      for (int i = 0; i < pat.len(); i++) begin
        b          = (pat[i] == 8'h31);
        e.m        = CH'(1) << ch;
        e.clk      = b ? e.m : '0;
        e.tk       = (b & ~p) ? e.m : '0;
        e.rdy_care = rc;
        e.rdy      = rv;
        sb.push_back(e);
        p = b;
      end
    end
  endtask

  task automatic push_vec(input logic [CH-1:0] m, input logic [CH-1:0] c, input logic [CH-1:0] t);
    exp_t e;
    e.m        = m;
    e.clk      = c;
    e.tk       = t;
    e.rdy_care = 1'b0;
    e.rdy      = 1'b0;
    sb.push_back(e);
  endtask

  task automatic run_check();
    exp_t e;
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      chk({tag, " clk_out"}, 32'(clk_out & e.m), 32'(e.clk & e.m));
      chk({tag, " tick"}, 32'(tick & e.m), 32'(e.tk & e.m));
      if (e.rdy_care) chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(e.rdy));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #3;
    chk("rst clk_out", 32'(clk_out), 0);
    chk("rst tick", 32'(tick), 0);
    chk("rst cfg_ready", 32'(cfg_ready), 1);
    chk("rst cfg_err", 32'(cfg_err), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    chk("post-rst clk_out", 32'(clk_out), 0);
    chk("post-rst tick", 32'(tick), 0);

    // Channel 0 at default divisor 2
    en[0] = 1'b1;
    tag = "t1 ch0 D2";
    push_pat(0, "10", 4, 1'b0, 1'b0, 1'b0);
    run_check();

    // Channel 1 programmed to 4 while idle
    cfg_chan = 3'd1; cfg_div = 16'd4; cfg_valid = 1'b1;
    #1;
    chk("t2 ready before write", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t2 ready while pending", 32'(cfg_ready), 0);
    chk("t2 no cfg_err", 32'(cfg_err), 0);
    step();
    chk("t2 ready after apply", 32'(cfg_ready), 1);
    en[1] = 1'b1;
    tag = "t2 ch1 D4";
    push_pat(1, "1100", 3, 1'b0, 1'b0, 1'b0);
    run_check();

    // Channel 2: D=5, then D=3 written mid-period
    cfg_chan = 3'd2; cfg_div = 16'd5; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    en[2] = 1'b1;
    tag = "t3 ch2 D5";
    push_pat(2, "11", 1, 1'b0, 1'b0, 1'b0);
    run_check();
    cfg_div = 16'd3; cfg_valid = 1'b1;
    push_pat(2, "1", 1, 1'b1, 1'b1, 1'b0);
    run_check();
    cfg_valid = 1'b0;
    tag = "t3 ch2 D5->D3";
    push_pat(2, "00", 1, 1'b1, 1'b0, 1'b0);
    push_pat(2, "110", 3, 1'b0, 1'b0, 1'b0);
    run_check();

    // Channel 3: D=8 running, two back-to-back writes (4 then 6)
    cfg_chan = 3'd3; cfg_div = 16'd8; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    en[3] = 1'b1;
    tag = "t4 ch3 D8";
    push_pat(3, "11", 1, 1'b0, 1'b0, 1'b0);
    run_check();
    cfg_div = 16'd4; cfg_valid = 1'b1;
    push_pat(3, "1", 1, 1'b1, 1'b1, 1'b0);
    run_check();
    cfg_div = 16'd6;
    tag = "t4 ch3 held";
    push_pat(3, "10000", 1, 1'b1, 1'b1, 1'b0);
    push_pat(3, "1", 1, 1'b0, 1'b1, 1'b1);
    push_pat(3, "1", 1, 1'b1, 1'b1, 1'b0);
    run_check();
    cfg_valid = 1'b0;
    tag = "t4 ch3 D4->D6";
    push_pat(3, "00", 1, 1'b1, 1'b0, 1'b0);
    push_pat(3, "111000", 2, 1'b0, 1'b0, 1'b0);
    run_check();

    // Rejected writes: divisor 1, channel out of range
    cfg_chan = 3'd0; cfg_div = 16'd1; cfg_valid = 1'b1;
    #1;
    chk("t5 ready div1", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t5 err div1", 32'(cfg_err), 1);
    chk("t5 ready after div1", 32'(cfg_ready), 1);
    step();
    chk("t5 err div1 clears", 32'(cfg_err), 0);
    cfg_chan = 3'd5; cfg_div = 16'd4; cfg_valid = 1'b1;
    #1;
    chk("t5 ready bad chan", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t5 err bad chan", 32'(cfg_err), 1);
    step();
    chk("t5 err bad chan clears", 32'(cfg_err), 0);
    cfg_chan = 3'd0;
    en = '0;
    step();
    en = 5'b00011;
    tag = "t5 ch0/ch1 unchanged";
    for (int k = 0; k < 2; k++) begin
      push_vec(5'b00011, 5'b00011, 5'b00011);
      push_vec(5'b00011, 5'b00010, 5'b00000);
      push_vec(5'b00011, 5'b00001, 5'b00001);
      push_vec(5'b00011, 5'b00000, 5'b00000);
    end
    run_check();

    // Async reset during the high phase with a write pending on ch3
    en = '0;
    step();
    en = 5'b01111;
    cfg_chan = 3'd3; cfg_div = 16'd10; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("t6 all high", 32'(clk_out), 32'h0F);
    chk("t6 all tick", 32'(tick), 32'h0F);
    chk("t6 ch3 pending", 32'(cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async clk_out", 32'(clk_out), 0);
    chk("t6 async tick", 32'(tick), 0);
    chk("t6 pend cleared", 32'(cfg_ready), 1);
    chk("t6 cfg_err", 32'(cfg_err), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    tag = "t6 restart D2";
    for (int k = 0; k < 3; k++) begin
      push_vec(5'b01111, 5'b01111, 5'b01111);
      push_vec(5'b01111, 5'b00000, 5'b00000);
    end
    run_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
